// File: rtl/float_class_unit_pkg.sv
// Shared constants for the float classifier: one-hot class codes and the
// counter slot index of each class.
package float_class_unit_pkg;

   localparam int NUM_CLS = 5;

   localparam logic [NUM_CLS-1:0] CLS_ZERO = 5'b00001;
   localparam logic [NUM_CLS-1:0] CLS_NORM = 5'b00010;
   localparam logic [NUM_CLS-1:0] CLS_SUB  = 5'b00100;
   localparam logic [NUM_CLS-1:0] CLS_INF  = 5'b01000;
   localparam logic [NUM_CLS-1:0] CLS_NAN  = 5'b10000;

   localparam int IDX_ZERO = 0;
   localparam int IDX_NORM = 1;
   localparam int IDX_SUB  = 2;
   localparam int IDX_INF  = 3;
   localparam int IDX_NAN  = 4;

endpackage

// File: rtl/float_class_unit_classify.sv
// Combinational IEEE-754-style classifier: one-hot class, sign and quiet-NaN
// flag for a {sign, exponent, mantissa} operand.
module float_classify
   import float_class_unit_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] num,
   output logic [NUM_CLS-1:0]   float_type,
   output logic                 sign,
   output logic                 qnan
);

   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man_f;
   logic             exp_zero;
   logic             exp_ones;
   logic             man_zero;

   assign sign  = num[EXP_W+MAN_W];
   assign exp_f = num[EXP_W+MAN_W-1 -: EXP_W];
   assign man_f = num[MAN_W-1:0];

   assign exp_zero = (exp_f == '0);
   assign exp_ones = &exp_f;
   assign man_zero = (man_f == '0);

   always_comb begin
      float_type = CLS_NORM;
      if (exp_zero)
         float_type = man_zero ? CLS_ZERO : CLS_SUB;
      else if (exp_ones)
         float_type = man_zero ? CLS_INF : CLS_NAN;
   end

   // Quiet NaN is distinguished by the mantissa MSB; only meaningful for NaN.
   assign qnan = exp_ones && !man_zero && man_f[MAN_W-1];

endmodule

// File: rtl/float_class_unit.sv
// Streaming float classifier with a one-deep registered valid/ready output
// stage and saturating per-class counters of accepted operands.
module float_class_unit
   import float_class_unit_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [EXP_W+MAN_W:0]       num,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_CLS-1:0]         float_type,
   output logic                       out_sign,
   output logic                       out_qnan,
   input  logic                       cnt_clear,
   output logic [NUM_CLS*CNT_W-1:0]   counts
);

   logic [NUM_CLS-1:0] cls;
   logic               cls_sign;
   logic               cls_qnan;
   logic               accept;

   logic               out_valid_q, out_valid_d;
   logic [NUM_CLS-1:0] type_q, type_d;
   logic               sign_q, sign_d;
   logic               qnan_q, qnan_d;

   float_classify #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_classify (
      .num        (num),
      .float_type (cls),
      .sign       (cls_sign),
      .qnan       (cls_qnan)
   );

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      type_d      = type_q;
      sign_d      = sign_q;
      qnan_d      = qnan_q;
      if (accept) begin
         out_valid_d = 1'b1;
         type_d      = cls;
         sign_d      = cls_sign;
         qnan_d      = cls_qnan;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         type_q      <= '0;
         sign_q      <= 1'b0;
         qnan_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         type_q      <= type_d;
         sign_q      <= sign_d;
         qnan_q      <= qnan_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign float_type = type_q;
   assign out_sign   = sign_q;
   assign out_qnan   = qnan_q;

   for (genvar k = 0; k < NUM_CLS; k++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             hit;

      assign hit = accept && cls[k];

      // Clear wins over the old value but a same-cycle sample still counts.
      always_comb begin
         cnt_d = cnt_q;
         if (cnt_clear)
            cnt_d = hit ? CNT_W'(1) : '0;
         else if (hit && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) cnt_q <= '0;
         else       cnt_q <= cnt_d;
      end

      assign counts[k*CNT_W +: CNT_W] = cnt_q;
   end

endmodule

// File: tb/tb_float_class_unit.sv
// Directed bench for float_class_unit: default single precision, a 2-bit
// counter build for saturation, and a half-precision build.
module tb_float_class_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // default build
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sign, a_out_qnan, a_cnt_clear;
   logic [31:0] a_num;
   logic [4:0]  a_type;
   logic [79:0] a_counts;
   // CNT_W=2 build
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sign, b_out_qnan, b_cnt_clear;
   logic [31:0] b_num;
   logic [4:0]  b_type;
   logic [9:0]  b_counts;
   // half precision build
   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_sign, c_out_qnan, c_cnt_clear;
   logic [15:0] c_num;
   logic [4:0]  c_type;
   logic [79:0] c_counts;

   float_class_unit u_a (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .num(a_num),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .float_type(a_type), .out_sign(a_out_sign),
      .out_qnan(a_out_qnan), .cnt_clear(a_cnt_clear), .counts(a_counts));

   float_class_unit #(.CNT_W(2)) u_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .num(b_num),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .float_type(b_type), .out_sign(b_out_sign),
      .out_qnan(b_out_qnan), .cnt_clear(b_cnt_clear), .counts(b_counts));

   float_class_unit #(.EXP_W(5), .MAN_W(10)) u_c (
      .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready), .num(c_num),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .float_type(c_type), .out_sign(c_out_sign),
      .out_qnan(c_out_qnan), .cnt_clear(c_cnt_clear), .counts(c_counts));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", a_out_valid); end
      checks++; if (a_type !== 5'b00000) begin errors++; $display("FAIL rst_type got %b exp 00000", a_type); end
      checks++; if (a_out_sign !== 1'b0 || a_out_qnan !== 1'b0) begin errors++; $display("FAIL rst_sign_qnan got %b%b exp 00", a_out_sign, a_out_qnan); end
      checks++; if (a_counts !== 80'd0) begin errors++; $display("FAIL rst_counts got %h exp 0", a_counts); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", a_in_ready); end
      checks++; if (b_counts !== 10'd0 || c_out_valid !== 1'b0) begin errors++; $display("FAIL rst_other got %h %b exp 0 0", b_counts, c_out_valid); end
   endtask

   task automatic test_classes;
      logic [31:0] v [5] = '{32'h0000_0000, 32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000};
      logic [4:0]  e [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a_num = v[i];
         tick();
         checks++; if (a_out_valid !== 1'b1 || a_type !== e[i]) begin errors++; $display("FAIL class_%0d got v=%b t=%b exp v=1 t=%b", i, a_out_valid, a_type, e[i]); end
         checks++; if (a_out_qnan !== (i == 4)) begin errors++; $display("FAIL qnan_%0d got %b exp %b", i, a_out_qnan, (i == 4)); end
      end
      a_in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++; if (a_counts[k*16 +: 16] !== 16'd1) begin errors++; $display("FAIL count_%0d got %0d exp 1", k, a_counts[k*16 +: 16]); end
      end
      tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL drain got %b exp 0", a_out_valid); end
   endtask

   task automatic test_sign;
      a_in_valid = 1'b1;
      a_num = 32'hFF80_0001;
      tick();
      checks++; if ({a_type, a_out_sign, a_out_qnan} !== {5'b10000, 1'b1, 1'b0}) begin errors++; $display("FAIL snan_neg got %b %b %b exp 10000 1 0", a_type, a_out_sign, a_out_qnan); end
      a_num = 32'h8000_0000;
      tick();
      checks++; if ({a_type, a_out_sign} !== {5'b00001, 1'b1}) begin errors++; $display("FAIL neg_zero got %b %b exp 00001 1", a_type, a_out_sign); end
      a_in_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure;
      // counts so far: zero 2, normal 1, sub 1, inf 1, nan 2
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_num = 32'h4000_0000;
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_type !== 5'b00010 || a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_load got v=%b t=%b r=%b exp 1 00010 0", a_out_valid, a_type, a_in_ready); end
      a_num = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (a_out_valid !== 1'b1 || a_type !== 5'b00010 || a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d got v=%b t=%b r=%b exp 1 00010 0", i, a_out_valid, a_type, a_in_ready); end
      end
      checks++; if (a_counts[0 +: 16] !== 16'd2 || a_counts[16 +: 16] !== 16'd2) begin errors++; $display("FAIL bp_counts got z=%0d n=%0d exp 2 2", a_counts[0 +: 16], a_counts[16 +: 16]); end
      a_out_ready = 1'b1;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got %b exp 1", a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_type !== 5'b00001) begin errors++; $display("FAIL bp_next got v=%b t=%b exp 1 00001", a_out_valid, a_type); end
      a_in_valid = 1'b0;
      tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", a_out_valid); end
      checks++; if (a_counts[0 +: 16] !== 16'd3 || a_counts[16 +: 16] !== 16'd2) begin errors++; $display("FAIL bp_final got z=%0d n=%0d exp 3 2", a_counts[0 +: 16], a_counts[16 +: 16]); end
   endtask

   task automatic test_saturation;
      logic [1:0] exp_n;
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_num = 32'h3F80_0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_n = (i >= 2) ? 2'd3 : 2'(i + 1);
         checks++; if (b_counts[3:2] !== exp_n) begin errors++; $display("FAIL sat_%0d got %0d exp %0d", i, b_counts[3:2], exp_n); end
      end
      b_cnt_clear = 1'b1;
      tick();
      checks++; if (b_counts !== 10'b00_00_00_01_00) begin errors++; $display("FAIL clr_accept got %b exp 0000000100", b_counts); end
      b_in_valid = 1'b0;
      tick();
      checks++; if (b_counts !== 10'd0) begin errors++; $display("FAIL clr_only got %b exp 0", b_counts); end
      b_cnt_clear = 1'b0;
   endtask

   task automatic test_half;
      logic [15:0] v [4] = '{16'h7C00, 16'h7E00, 16'h0200, 16'h3C00};
      logic [4:0]  e [4] = '{5'b01000, 5'b10000, 5'b00100, 5'b00010};
      c_out_ready = 1'b1;
      c_in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         c_num = v[i];
         tick();
         checks++; if (c_type !== e[i] || c_out_qnan !== (i == 1)) begin errors++; $display("FAIL half_%0d got t=%b q=%b exp t=%b q=%b", i, c_type, c_out_qnan, e[i], (i == 1)); end
      end
      c_in_valid = 1'b0;
      checks++; if (c_counts[15:0] !== 16'd0 || c_counts[79:64] !== 16'd1 || c_counts[31:16] !== 16'd1) begin errors++; $display("FAIL half_counts got %h exp zero 0 nan 1 norm 1", c_counts); end
      tick();
   endtask

   task automatic test_reset_async;
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_num = 32'h7F80_0000;
      tick();
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got %b exp 1", a_out_valid); end
      a_in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (a_out_valid !== 1'b0 || a_type !== 5'b0 || a_counts !== 80'd0) begin errors++; $display("FAIL ar_async got v=%b t=%b c=%h exp 0 0 0", a_out_valid, a_type, a_counts); end
      #2 reset = 1'b0;
      a_num = 32'h0000_0001;
      a_in_valid  = 1'b1;
      a_out_ready = 1'b1;
      #1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL ar_idle got %b exp 0", a_out_valid); end
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_type !== 5'b00100 || a_counts[32 +: 16] !== 16'd1) begin errors++; $display("FAIL ar_first got v=%b t=%b sub=%0d exp 1 00100 1", a_out_valid, a_type, a_counts[32 +: 16]); end
      a_in_valid = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      {a_in_valid, a_out_ready, a_cnt_clear, b_in_valid, b_out_ready, b_cnt_clear, c_in_valid, c_out_ready, c_cnt_clear} = '0;
      a_num = '0; b_num = '0; c_num = '0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      test_reset();
      test_classes();
      test_sign();
      test_backpressure();
      test_saturation();
      test_half();
      test_reset_async();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/float_class_unit.md
# float_class_unit

Streaming IEEE-754-style floating-point classifier with parametrised exponent and mantissa widths. Each accepted operand is classified into one of five one-hot classes (zero, normal, subnormal, infinity, NaN), together with its sign and a quiet/signalling-NaN flag. Results leave through a one-deep registered output stage with a valid/ready handshake. Saturating per-class occurrence counters run alongside. The block sits between an operand source and any consumer that needs class information, such as exception logic or a statistics readout.

## Interface
Parameters:
- EXP_W, 8, exponent field width (≥2)
- MAN_W, 23, mantissa field width (≥2)
- CNT_W, 16, width of each per-class counter (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operand present
- in_ready  out  1  block can accept operand this cycle
- num  in  EXP_W+MAN_W+1  operand: sign at MSB, then exponent, then mantissa
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  consumer takes result this cycle
- float_type  out  5  one-hot class: bit0 zero, bit1 normal, bit2 subnormal, bit3 infinity, bit4 NaN
- out_sign  out  1  sign bit of classified operand
- out_qnan  out  1  1 when class is NaN and mantissa MSB is 1; otherwise 0
- cnt_clear  in  1  synchronous clear of all counters
- counts  out  5*CNT_W  counters packed in class order; class k occupies bits [k*CNT_W +: CNT_W]

## Operation
Classification uses exponent E and mantissa M:
- zero: E==0 and M==0
- subnormal: E==0 and M!=0
- normal: E not 0 and not all-ones
- infinity: E all-ones and M==0
- NaN: E all-ones and M!=0

Exactly one float_type bit is set for a valid result. Sign does not affect the class.

Handshake:
- accept = in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational, with no path from in_valid.
- On accept, the result registers load the new classification and out_valid is set to 1.
- On out_valid && out_ready with no accept, out_valid is cleared to 0. The data registers keep their values.
- While out_valid && !out_ready, the result registers hold stable, and in_ready is 0.

Counters:
- On accept, the counter of the accepted class increments by 1.
- Each counter saturates at 2^CNT_W−1 and does not wrap.
- When cnt_clear is asserted, all counters go to 0. If an accept happens in the same cycle, the accepted class's counter becomes 1. Clear takes priority over old values, but the concurrent sample is still counted.
- Counters never count results; they count accepted inputs.

## Timing
- Reset values:
  - out_valid=0, float_type=5'b00000, out_sign=0, out_qnan=0, counts all 0.
  - in_ready reads 1 after reset.
- Latency: an operand accepted in cycle n is presented at out_valid/float_type in cycle n+1.
- Throughput: one operand per cycle while out_ready is held at 1.
- Simultaneous drain and accept in the same cycle: out_valid stays 1 and the result registers are replaced by the new result.
- counts reflects an accept one cycle after the accept edge.
- Reset asserted mid-stream: the pending result is discarded immediately (asynchronous), and the counters clear. No partial transfer is observed after reset deasserts.

## Structure
- Shared package holds:
  - the five one-hot class constants (CLS_ZERO=5'b00001, CLS_NORM=5'b00010, CLS_SUB=5'b00100, CLS_INF=5'b01000, CLS_NAN=5'b10000)
  - the class index constants 0–4 used for counter packing
- One sub-module, float_classify: purely combinational, parametrised by EXP_W and MAN_W, producing the class, sign and qnan.
- The top level holds the output register stage, the handshake, and five instances of saturating-counter logic (a generate loop).

## Test plan
- Default params, out_ready=1, stream 0x00000000, 0x3F800000, 0x00000001, 0x7F800000, 0x7FC00000 → float_type one cycle later is 00001, 00010, 00100, 01000, 10000. out_qnan is 1 only for the last. counts are 1 in every class.
- 0xFF800001 → float_type 10000, out_sign=1, out_qnan=0. 0x80000000 → float_type 00001, out_sign=1.
- Hold out_ready=0 with in_valid=1 for 4 cycles → in_ready=0 and the result stays stable. Then raise out_ready → each operand is delivered exactly once, in order, and no counter is double-incremented.
- CNT_W=2, feed 5 normals → normal counter reads 3 (saturated). Then assert cnt_clear together with accepting a normal → the counter reads 1 and all other counters read 0.
- EXP_W=5, MAN_W=10, inputs 0x7C00, 0x7E00, 0x0200, 0x3C00 → classes infinity, NaN (qnan=1), subnormal, normal.
- Assert reset while out_valid=1 and out_ready=0 → out_valid=0 and counts=0 immediately, without waiting for a clock edge. After release, the first accepted operand appears at cycle n+1.
